// File: rtl/pipelined_word_mux_if.sv
// Request/response bundle for the pipelined word mux: flattened word bus and
// select on the request side, selected word and its valid flag on the response side.
interface pipelined_word_mux_if #(
    parameter int WIDTH = 64,
    parameter int SEL_W = 5
);
    localparam int N = 1 << SEL_W;

    logic                 in_valid;
    logic                 stall;
    logic [SEL_W-1:0]     sel;
    logic [WIDTH*N-1:0]   w;
    logic [WIDTH-1:0]     out;
    logic                 out_valid;

    modport master (
        output in_valid, stall, sel, w,
        input  out, out_valid
    );

    modport slave (
        input  in_valid, stall, sel, w,
        output out, out_valid
    );
endinterface

// File: rtl/pipelined_word_mux.sv
// Pipelined 2^SEL_W:1 word mux built from registered 4:1 levels (a 2:1 last level
// when SEL_W is odd); a valid bit and the unconsumed select bits travel alongside.
module pipelined_word_mux #(
    parameter int WIDTH = 64,
    parameter int SEL_W = 5
) (
    input logic                  clk,
    input logic                  reset,
    pipelined_word_mux_if.slave  bus
);
    localparam int L = (SEL_W + 1) / 2;

    // Select bits still unconsumed once level k has been registered.
    function automatic int sel_left(input int k);
        return (2 * k + 2 >= SEL_W) ? 0 : SEL_W - 2 * k - 2;
    endfunction

    function automatic int words_after(input int k);
        return 1 << sel_left(k);
    endfunction

    function automatic int d_ofs(input int k);
        int s = 0;
        for (int unsigned j = 0; j < k; j++) s += words_after(j) * WIDTH;
        return s;
    endfunction

    function automatic int s_ofs(input int k);
        int s = 0;
        for (int unsigned j = 0; j < k; j++) s += sel_left(j);
        return s;
    endfunction

    localparam int D_TOT = d_ofs(L);
    localparam int S_TOT = s_ofs(L);
    localparam int S_W   = (S_TOT > 0) ? S_TOT : 1;

    // All levels' partial words / remaining selects packed end to end, level 0 at bit 0.
    logic [D_TOT-1:0] data_q, data_d;
    logic [S_W-1:0]   sel_q, sel_d;
    logic [L-1:0]     vld_q, vld_d;

    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = bus.in_valid;
    end

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int          SIN   = SEL_W - 2 * k;
        localparam int          B     = (SIN >= 2) ? 2 : 1;
        localparam int          IN_N  = 1 << SIN;
        localparam int          OUT_N = 1 << (SIN - B);
        localparam int unsigned FAN   = 1 << B;

        logic [WIDTH*IN_N-1:0]  src;
        logic [SIN-1:0]         s_src;
        logic [WIDTH*OUT_N-1:0] red;

        if (k == 0) begin : g_first
            assign src   = bus.w;
            assign s_src = bus.sel;
        end else begin : g_next
            assign src   = data_q[d_ofs(k-1) +: WIDTH*IN_N];
            assign s_src = sel_q[s_ofs(k-1) +: SIN];
        end

        always_comb begin
            red = '0;
            for (int unsigned o = 0; o < OUT_N; o++) begin
                red[o*WIDTH +: WIDTH] = src[(o * FAN + 32'(s_src[B-1:0])) * WIDTH +: WIDTH];
            end
        end

        if (k == L - 1) begin : g_out
            // The output word only moves on a valid result so it holds between requests.
            assign data_d[d_ofs(k) +: WIDTH] = vld_d[k] ? red : data_q[d_ofs(k) +: WIDTH];
        end else begin : g_mid
            assign data_d[d_ofs(k) +: WIDTH*OUT_N] = red;
            assign sel_d[s_ofs(k) +: SIN-B]        = s_src[SIN-1:B];
        end
    end

    if (S_TOT == 0) begin : g_nosel
        assign sel_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            sel_q  <= '0;
            vld_q  <= '0;
        end else if (!bus.stall) begin
            data_q <= data_d;
            sel_q  <= sel_d;
            vld_q  <= vld_d;
        end
    end

    assign bus.out       = data_q[d_ofs(L-1) +: WIDTH];
    assign bus.out_valid = vld_q[L-1];
endmodule

// File: tb/tb_pipelined_word_mux.sv
// Directed and randomised checks of pipelined_word_mux: latency, hold, stall,
// async reset, one-hot isolation, and SEL_W = 1/4/7 against a reference model.
module tb_pipelined_word_mux;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipelined_word_mux_if #(.WIDTH(64), .SEL_W(5)) m_if ();
    pipelined_word_mux_if #(.WIDTH(8),  .SEL_W(1)) s1_if ();
    pipelined_word_mux_if #(.WIDTH(8),  .SEL_W(4)) s4_if ();
    pipelined_word_mux_if #(.WIDTH(8),  .SEL_W(7)) s7_if ();

    pipelined_word_mux #(.WIDTH(64), .SEL_W(5)) dut    (.clk(clk), .reset(rst_n), .bus(m_if));
    pipelined_word_mux #(.WIDTH(8),  .SEL_W(1)) dut_s1 (.clk(clk), .reset(rst_n), .bus(s1_if));
    pipelined_word_mux #(.WIDTH(8),  .SEL_W(4)) dut_s4 (.clk(clk), .reset(rst_n), .bus(s4_if));
    pipelined_word_mux #(.WIDTH(8),  .SEL_W(7)) dut_s7 (.clk(clk), .reset(rst_n), .bus(s7_if));

    // Reference pipelines: index 0 = main DUT, 1/2/3 = SEL_W 1/4/7.
    int unsigned lat [4] = '{3, 1, 2, 4};
    logic        mv  [4][4];
    logic [63:0] md  [4][4];
    logic [63:0] mo  [4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_reset(input int unsigned d);
        for (int unsigned j = 0; j < 4; j++) begin
            mv[d][j] = 1'b0;
            md[d][j] = '0;
        end
        mo[d] = '0;
    endtask

    task automatic mdl_step(input int unsigned d, input logic st, input logic v, input logic [63:0] e);
        if (!st) begin
            for (int unsigned j = lat[d] - 1; j > 0; j--) begin
                mv[d][j] = mv[d][j-1];
                md[d][j] = md[d][j-1];
            end
            mv[d][0] = v;
            md[d][0] = e;
            if (mv[d][lat[d]-1]) mo[d] = md[d][lat[d]-1];
        end
    endtask

    function automatic logic [2047:0] ref_words();
        logic [2047:0] r;
        for (int unsigned i = 0; i < 32; i++) r[i*64 +: 64] = 64'hA5A5_0000_0000_0000 + 64'(i);
        return r;
    endfunction

    initial begin
        #5_000_000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [63:0]   exp_b2b [4];
        logic [4:0]    sel_b2b [4];
        logic [1023:0] rw;
        logic [63:0]   e;
        logic          st1, st4, st7, v1, v4, v7;

        sel_b2b = '{5'd0, 5'd1, 5'd30, 5'd31};
        exp_b2b = '{64'hA5A5_0000_0000_0000, 64'hA5A5_0000_0000_0001,
                    64'hA5A5_0000_0000_001E, 64'hA5A5_0000_0000_001F};

        rst_n = 1'b0;
        m_if.in_valid  = 1'b0; m_if.stall  = 1'b0; m_if.sel  = '0; m_if.w  = ref_words();
        s1_if.in_valid = 1'b0; s1_if.stall = 1'b0; s1_if.sel = '0; s1_if.w = '0;
        s4_if.in_valid = 1'b0; s4_if.stall = 1'b0; s4_if.sel = '0; s4_if.w = '0;
        s7_if.in_valid = 1'b0; s7_if.stall = 1'b0; s7_if.sel = '0; s7_if.w = '0;

        // Reset held two cycles, then idle.
        step(); step();
        chk("rst_out", m_if.out, 64'h0);
        chk("rst_vld", 64'(m_if.out_valid), 64'h0);
        rst_n = 1'b1;
        step();
        chk("idle_out", m_if.out, 64'h0);
        chk("idle_vld", 64'(m_if.out_valid), 64'h0);

        // Single request, latency 3, then hold.
        m_if.sel = 5'd19; m_if.in_valid = 1'b1;
        step();
        m_if.in_valid = 1'b0;
        chk("single_c1_vld", 64'(m_if.out_valid), 64'h0);
        step();
        chk("single_c2_vld", 64'(m_if.out_valid), 64'h0);
        step();
        chk("single_c3_vld", 64'(m_if.out_valid), 64'h1);
        chk("single_c3_out", m_if.out, 64'hA5A5_0000_0000_0013);
        step();
        chk("single_c4_vld", 64'(m_if.out_valid), 64'h0);
        chk("single_c4_out", m_if.out, 64'hA5A5_0000_0000_0013);

        // Back-to-back with w scrambled right after every sample.
        for (int unsigned c = 0; c < 6; c++) begin
            if (c < 4) begin
                m_if.w = ref_words(); m_if.sel = sel_b2b[c]; m_if.in_valid = 1'b1;
            end else begin
                m_if.in_valid = 1'b0;
            end
            step();
            m_if.w = '1;
            if (c >= 2) begin
                chk("b2b_vld", 64'(m_if.out_valid), 64'h1);
                chk("b2b_out", m_if.out, exp_b2b[c-2]);
            end
        end
        step();
        chk("b2b_end_vld", 64'(m_if.out_valid), 64'h0);
        m_if.w = ref_words();

        // Stall for four cycles after accepting sel=7; a request during stall is dropped.
        m_if.sel = 5'd7; m_if.in_valid = 1'b1;
        step();
        m_if.stall = 1'b1;
        for (int unsigned c = 2; c <= 5; c++) begin
            m_if.in_valid = (c == 3);
            m_if.sel = (c == 3) ? 5'd3 : 5'd7;
            step();
            chk("stall_hold_vld", 64'(m_if.out_valid), 64'h0);
        end
        m_if.stall = 1'b0; m_if.in_valid = 1'b0;
        step();
        chk("stall_c6_vld", 64'(m_if.out_valid), 64'h0);
        step();
        chk("stall_c7_vld", 64'(m_if.out_valid), 64'h1);
        chk("stall_c7_out", m_if.out, 64'hA5A5_0000_0000_0007);
        step();
        chk("stall_c8_vld", 64'(m_if.out_valid), 64'h0);
        step(); step();
        chk("stall_nodrop_vld", 64'(m_if.out_valid), 64'h0);
        chk("stall_nodrop_out", m_if.out, 64'hA5A5_0000_0000_0007);

        // Asynchronous reset mid-stream discards in-flight work.
        m_if.sel = 5'd2; m_if.in_valid = 1'b1;
        step();
        m_if.sel = 5'd9;
        step();
        m_if.in_valid = 1'b0;
        step();
        chk("pre_rst_vld", 64'(m_if.out_valid), 64'h1);
        chk("pre_rst_out", m_if.out, 64'hA5A5_0000_0000_0002);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_vld", 64'(m_if.out_valid), 64'h0);
        chk("async_rst_out", m_if.out, 64'h0);
        step();
        rst_n = 1'b1;
        for (int unsigned c = 0; c < 3; c++) begin
            step();
            chk("post_rst_vld", 64'(m_if.out_valid), 64'h0);
            chk("post_rst_out", m_if.out, 64'h0);
        end

        // One-hot isolation: only word k is all-ones, sel sweeps every index.
        mdl_reset(0);
        for (int unsigned k = 0; k < 33; k++) begin
            for (int unsigned s = 0; s < 32; s++) begin
                if (k < 32) begin
                    m_if.w = '0;
                    m_if.w[k*64 +: 64] = '1;
                    m_if.sel = 5'(s);
                    m_if.in_valid = 1'b1;
                    e = (s == k) ? '1 : '0;
                end else begin
                    m_if.in_valid = 1'b0;
                    e = '0;
                end
                step();
                mdl_step(0, 1'b0, m_if.in_valid, e);
                if (k < 32 || s < 4) begin
                    chk("iso_vld", 64'(m_if.out_valid), 64'(mv[0][2]));
                    chk("iso_out", m_if.out, mo[0]);
                end
            end
        end

        // Randomised SEL_W = 1/4/7 runs with random stalls and bubbles.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int unsigned d = 1; d < 4; d++) mdl_reset(d);
        for (int unsigned cyc = 0; cyc < 1500; cyc++) begin
            for (int unsigned j = 0; j < 32; j++) rw[j*32 +: 32] = $urandom;
            st1 = ($urandom_range(7) == 0); v1 = ($urandom_range(7) != 0);
            st4 = ($urandom_range(7) == 0); v4 = ($urandom_range(7) != 0);
            st7 = ($urandom_range(7) == 0); v7 = ($urandom_range(7) != 0);
            s1_if.w = rw[1023:1008]; s1_if.sel = 1'($urandom_range(1));
            s4_if.w = rw[900:773];   s4_if.sel = 4'($urandom_range(15));
            s7_if.w = rw;            s7_if.sel = 7'($urandom_range(127));
            s1_if.stall = st1; s1_if.in_valid = v1;
            s4_if.stall = st4; s4_if.in_valid = v4;
            s7_if.stall = st7; s7_if.in_valid = v7;
            step();
            mdl_step(1, st1, v1, 64'(s1_if.w[s1_if.sel*8 +: 8]));
            mdl_step(2, st4, v4, 64'(s4_if.w[s4_if.sel*8 +: 8]));
            mdl_step(3, st7, v7, 64'(s7_if.w[s7_if.sel*8 +: 8]));
            chk("sw1_vld", 64'(s1_if.out_valid), 64'(mv[1][0]));
            chk("sw1_out", 64'(s1_if.out), mo[1]);
            chk("sw4_vld", 64'(s4_if.out_valid), 64'(mv[2][1]));
            chk("sw4_out", 64'(s4_if.out), mo[2]);
            chk("sw7_vld", 64'(s7_if.out_valid), 64'(mv[3][3]));
            chk("sw7_out", 64'(s7_if.out), mo[3]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipelined_word_mux.md
Name: pipelined_word_mux

Overview:
- Parametrised, pipelined N:1 word multiplexer. Successor to the bit-wide 32:1 register-file read mux.
- Selects one WIDTH-bit word from 2^SEL_W inputs using a tree of 4:1 levels, with a register after every level.
- Carries a valid bit and a stall control so it can sit directly in the processor's register-read pipeline stage.

Parameters:
- WIDTH, 64, bits per word.
- SEL_W, 5, select width; number of inputs N = 2^SEL_W; legal range 1..8.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  sel and w are valid this cycle.
- stall  input  1  when 1, every pipeline register holds its value.
- sel  input  SEL_W  word index; 0 selects w[WIDTH-1:0].
- w  input  WIDTH*N  flattened input words; word i is w[WIDTH*i +: WIDTH].
- out  output  WIDTH  selected word.
- out_valid  output  1  out holds the word for a sampled request.

Behaviour:
- Levels: L = ceil(SEL_W/2).
  - Level k (k = 0..L-1) consumes sel bits [2k+1:2k] and does a 4:1 reduction.
  - If SEL_W is odd, the final level uses only sel[SEL_W-1] as a 2:1 reduction.
  - Level 0 selects within groups of 4 adjacent words, LSB-first, matching the 16/32:1 decomposition.
- Registers after each level:
  - The reduced partial words.
  - The not-yet-consumed sel bits.
  - A valid bit.
- Latency: exactly L cycles from a sampling edge with in_valid=1 and stall=0 to out/out_valid. Default SEL_W=5 gives L=3.
- Input timing: w and sel only need to be stable at the sampling edge; later changes do not affect in-flight requests.
- Throughput: one request per cycle, fully pipelined, no bubbles inserted.
- Stall:
  - While stall=1, no register changes, including valid bits.
  - in_valid is ignored during stall, so the requester must hold its request.
  - When stall deasserts, the pipeline resumes with no loss or duplication.
- in_valid=0 with stall=0: a 0 valid bit advances. Data registers still load but are don't-care.
  - Exception: the output data register loads only when its incoming valid bit is 1.
  - So out holds the last valid result while out_valid=0.
- Reset (asynchronous, active-low):
  - All valid bits, out and all partial registers clear to 0 immediately.
  - Reset mid-operation discards all in-flight requests; out_valid=0 from reset assertion until L cycles after the first post-reset accepted request.
- Simultaneous stall=1 and in_valid=1: stall wins; the request is not accepted.
- SEL_W=1: L=1, a single registered 2:1.
- SEL_W=2: L=1, a single registered 4:1.
- No state machine beyond the valid shift chain. No arithmetic.
- Out-of-range sel is impossible because N = 2^SEL_W.

Test Plan (WIDTH=64, SEL_W=5, word i = 64'hA5A5_0000_0000_0000 + i unless stated):
- Reset: hold reset=0 for 2 cycles, release → out=0 and out_valid=0 until a request is accepted; assert reset mid-stream → out_valid drops to 0 asynchronously.
- Single request sel=5'd19 at cycle 0 → exactly 3 cycles later out=64'hA5A5_0000_0000_0013 and out_valid=1; the next cycle out_valid=0 and out holds.
- Back-to-back sel=0,1,30,31 on consecutive cycles, with w changed to all-ones immediately after each sample → outputs ...0000, ...0001, ...001E, ...001F on 4 consecutive cycles starting at cycle 3, unaffected by the w changes.
- Stall: request sel=7, assert stall for 4 cycles at cycle 1 → result appears at cycle 7, once only; an in_valid=1 pulse presented during the stall is not output.
- Parameter sweep: SEL_W=1, 4, 7 with WIDTH=8 and random sel/w (1000 requests each) → latency 1, 2, 4 respectively; every output equals the reference word w[sel].
- Bit isolation: one-hot w (only word k = all-ones, others 0) for each k, with sel sweeping 0..31 → out is all-ones only when sel=k.
